// File: rtl/int_sequencer.sv
// Interrupt front-end and exception-entry sequencer for cp0: latches device lines into
// pending bits, drains the pipeline, saves EPC and redirects fetch. Option: INTSEQ_SYNC_EN.
`ifndef CP0_REG_SEL_EPC
`define CP0_REG_SEL_EPC 5'd14
`endif

module int_sequencer #(
    parameter logic [29:0] VEC_ADDR  = 30'h0000_1060,
    parameter logic [3:0]  DRAIN_MAX = 4'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  irq_src,
    input  logic [5:0]  edge_mode,
    input  logic        int_request,
    input  logic [29:0] epc,
    input  logic        entry_ack,
    input  logic        eret,
    output logic [5:0]  hw_int,
    output logic        cp0_write_en,
    output logic [4:0]  cp0_reg_sel,
    output logic        exl_set,
    output logic        exl_clr,
    output logic        entry_req,
    output logic        redirect,
    output logic [29:0] redirect_pc,
    output logic [2:0]  int_id,
    output logic        drain_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_SAVE    = 3'd2,
        S_ENTER   = 3'd3,
        S_SERVICE = 3'd4,
        S_RETURN  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  int_id_q, int_id_d;
    logic [5:0]  pend_q, pend_d;
    logic [5:0]  prev_q;
    logic [5:0]  src_s;
    logic        timeout_s;

    logic        cp0_write_en_q, cp0_write_en_d;
    logic        exl_set_q, exl_set_d;
    logic        exl_clr_q, exl_clr_d;
    logic        entry_req_q, entry_req_d;
    logic        redirect_q, redirect_d;
    logic [29:0] redirect_pc_q, redirect_pc_d;
    logic        drain_err_q, drain_err_d;

    function automatic logic [2:0] lowest_set(input logic [5:0] v);
        logic [2:0] id;
        id = 3'd7;
        for (int i = 5; i >= 0; i--) begin
            if (v[i]) begin
                id = 3'(i);
            end
        end
        return id;
    endfunction

`ifdef INTSEQ_SYNC_EN
    logic [5:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous device lines
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 6'd0;
            sync2_q <= 6'd0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = irq_src;
`endif

    // Pending bits: level sources follow the line, edge sources latch until entry (set wins)
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < 6; i++) begin
            if (edge_mode[i]) begin
                if (src_s[i] && !prev_q[i]) begin
                    pend_d[i] = 1'b1;
                end else if ((state_q == S_ENTER) && (int_id_q == 3'(i))) begin
                    pend_d[i] = 1'b0;
                end else begin
                    pend_d[i] = pend_q[i];
                end
            end else begin
                pend_d[i] = src_s[i];
            end
        end
    end

    // Next-state, drain counter and in-service id
    always_comb begin
        state_d   = state_q;
        cnt_d     = 4'd0;
        int_id_d  = int_id_q;
        timeout_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                int_id_d = lowest_set(pend_q & hw_int);
                if (int_request) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 4'd1;
                if (entry_ack) begin
                    state_d = S_SAVE;
                end else if (!int_request) begin
                    state_d  = S_IDLE;
                    int_id_d = 3'd7;
                end else if (cnt_d == DRAIN_MAX) begin
                    state_d   = S_IDLE;
                    int_id_d  = 3'd7;
                    timeout_s = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_SAVE:    state_d = S_ENTER;
            S_ENTER:   state_d = S_SERVICE;
            S_SERVICE: begin
                if (eret) begin
                    state_d = S_RETURN;
                end else begin
                    state_d = S_SERVICE;
                end
            end
            S_RETURN: begin
                state_d  = S_IDLE;
                int_id_d = 3'd7;
            end
            default: begin
                state_d  = S_IDLE;
                int_id_d = 3'd7;
            end
        endcase
    end

    // Outputs decoded from the next state so they land registered with the state
    always_comb begin
        entry_req_d    = (state_d == S_DRAIN);
        cp0_write_en_d = (state_d == S_SAVE);
        exl_set_d      = (state_d == S_ENTER);
        exl_clr_d      = (state_d == S_RETURN);
        redirect_d     = (state_d == S_ENTER) || (state_d == S_RETURN);
        drain_err_d    = drain_err_q | timeout_s;
        if (state_d == S_ENTER) begin
            redirect_pc_d = VEC_ADDR;
        end else if (state_d == S_RETURN) begin
            redirect_pc_d = epc;
        end else begin
            redirect_pc_d = 30'd0;
        end
    end

    // State, counter, id and pending registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            int_id_q <= 3'd7;
            pend_q   <= 6'd0;
            prev_q   <= 6'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            int_id_q <= int_id_d;
            pend_q   <= pend_d;
            prev_q   <= src_s;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cp0_write_en_q <= 1'b0;
            exl_set_q      <= 1'b0;
            exl_clr_q      <= 1'b0;
            entry_req_q    <= 1'b0;
            redirect_q     <= 1'b0;
            redirect_pc_q  <= 30'd0;
            drain_err_q    <= 1'b0;
        end else begin
            cp0_write_en_q <= cp0_write_en_d;
            exl_set_q      <= exl_set_d;
            exl_clr_q      <= exl_clr_d;
            entry_req_q    <= entry_req_d;
            redirect_q     <= redirect_d;
            redirect_pc_q  <= redirect_pc_d;
            drain_err_q    <= drain_err_d;
        end
    end

    assign hw_int       = pend_q;
    assign int_id       = int_id_q;
    assign cp0_reg_sel  = `CP0_REG_SEL_EPC;
    assign cp0_write_en = cp0_write_en_q;
    assign exl_set      = exl_set_q;
    assign exl_clr      = exl_clr_q;
    assign entry_req    = entry_req_q;
    assign redirect     = redirect_q;
    assign redirect_pc  = redirect_pc_q;
    assign drain_err    = drain_err_q;

endmodule
